// File: rtl/rect_calc_pkg.sv
// Shared encodings and mode constants for the rectangle area/perimeter calculator.
package rect_calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_PER,
    S_OUT_WAIT,
    S_OUT_DAV
  } core_state_t;

  typedef enum logic [1:0] {
    CH_EMPTY,
    CH_ACK,
    CH_FULL
  } chan_state_t;

  localparam logic MODE_AREA  = 1'b0;
  localparam logic MODE_PERIM = 1'b1;

endpackage

// File: rtl/rect_calc_if.sv
// Producer/consumer handshake bundle; the calculator uses the slave side.
interface rect_calc_if #(
  parameter int W = 8
);
  logic [W-1:0]   data_in_1;
  logic           dav_in_1_;
  logic           rfd_in_1;
  logic [W-1:0]   data_in_2;
  logic           dav_in_2_;
  logic           rfd_in_2;
  logic           mode_in;
  logic [2*W-1:0] data_out;
  logic           dav_out_;
  logic           rfd_out;

  modport master (
    output data_in_1, dav_in_1_, data_in_2, dav_in_2_, mode_in, rfd_out,
    input  rfd_in_1, rfd_in_2, data_out, dav_out_
  );

  modport slave (
    input  data_in_1, dav_in_1_, data_in_2, dav_in_2_, mode_in, rfd_out,
    output rfd_in_1, rfd_in_2, data_out, dav_out_
  );
endinterface

// File: rtl/rect_calc_chan.sv
// One input channel: captures a word on dav_ low, then holds it until the core loads it.
//   state    | meaning
//   CH_EMPTY | ready for data (rfd=1), waiting for dav_=0
//   CH_ACK   | word captured, waiting for producer to release dav_
//   CH_FULL  | word held for the core; dav_ ignored until load
module rect_calc_chan
  import rect_calc_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          dav_in_,
  input  logic          load,
  output logic          rfd,
  output logic          full,
  output logic [DW-1:0] data_q
);

  chan_state_t   state_q, state_d;
  logic [DW-1:0] data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      CH_EMPTY: begin
        if (!dav_in_) begin
          data_d  = data_in;
          state_d = CH_ACK;
        end
      end
      CH_ACK:  if (dav_in_) state_d = CH_FULL;
      CH_FULL: if (load) state_d = CH_EMPTY;
      default: state_d = CH_EMPTY;
    endcase
  end

  assign rfd  = (state_q == CH_EMPTY);
  assign full = (state_q == CH_FULL);

endmodule

// File: rtl/rect_calc_param.sv
// Rectangle calculator: area by W-step shift-add multiply, or perimeter 2*(A+B) in one step.
//   state      | meaning
//   S_IDLE     | waiting for both channels FULL, then load operands
//   S_MUL      | one shift-add step per cycle, W steps
//   S_PER      | single-cycle perimeter
//   S_OUT_WAIT | result on data_out, waiting for consumer rfd_out=1
//   S_OUT_DAV  | dav_out_ low until consumer drops rfd_out
module rect_calc_param
  import rect_calc_pkg::*;
#(
  parameter int W = 8
) (
  input logic        clock,
  input logic        reset,
  rect_calc_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  logic           full_1, full_2, load;
  logic [W:0]     chan1_data, chan2_data;

  core_state_t    state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W:0]     b_q, b_d;        // top bit always zero; channel 2 carries no mode bit
  logic [2*W-1:0] p_q, p_d;
  logic [CW-1:0]  count_q, count_d;
  logic           dav_out_q, dav_out_d;
  logic [2*W:0]   mul_sum;
  logic [W:0]     per_sum;

  rect_calc_chan #(.DW(W + 1)) u_chan_1 (
    .clock   (clock),
    .reset   (reset),
    .data_in ({bus.mode_in, bus.data_in_1}),
    .dav_in_ (bus.dav_in_1_),
    .load    (load),
    .rfd     (bus.rfd_in_1),
    .full    (full_1),
    .data_q  (chan1_data)
  );

  rect_calc_chan #(.DW(W + 1)) u_chan_2 (
    .clock   (clock),
    .reset   (reset),
    .data_in ({1'b0, bus.data_in_2}),
    .dav_in_ (bus.dav_in_2_),
    .load    (load),
    .rfd     (bus.rfd_in_2),
    .full    (full_2),
    .data_q  (chan2_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      count_q   <= count_d;
      dav_out_q <= dav_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    count_d   = count_q;
    dav_out_d = 1'b1;
    load      = 1'b0;
    // Partial product kept on 2W+1 bits so the add never loses its carry before the shift.
    mul_sum   = {1'b0, p_q} + (b_q[0] ? {1'b0, a_q, {W{1'b0}}} : '0);
    per_sum   = {1'b0, a_q} + b_q;

    unique case (state_q)
      S_IDLE: begin
        if (full_1 && full_2) begin
          load    = 1'b1;
          a_d     = chan1_data[W-1:0];
          b_d     = chan2_data;
          p_d     = '0;
          count_d = CW'(W);
          state_d = (chan1_data[W] == MODE_PERIM) ? S_PER : S_MUL;
        end
      end
      S_MUL: begin
        p_d     = (2*W)'(mul_sum >> 1);
        b_d     = b_q >> 1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_OUT_WAIT;
      end
      S_PER: begin
        p_d     = (2*W)'({per_sum, 1'b0});
        state_d = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (bus.rfd_out) begin
          dav_out_d = 1'b0;
          state_d   = S_OUT_DAV;
        end
      end
      S_OUT_DAV: begin
        if (bus.rfd_out) dav_out_d = 1'b0;
        else             state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_out = p_q;
  assign bus.dav_out_ = dav_out_q;

endmodule

// File: tb/tb_rect_calc_param.sv
// Self-checking bench for rect_calc_param (W=8 main instance, W=4 secondary instance).
module tb_rect_calc_param;
  import rect_calc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rect_calc_if #(.W(8)) b8 ();
  rect_calc_if #(.W(4)) b4 ();

  rect_calc_param #(.W(8)) dut8 (.clock(clock), .reset(reset), .bus(b8.slave));
  rect_calc_param #(.W(4)) dut4 (.clock(clock), .reset(reset), .bus(b4.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int model(input int a, input int b, input logic m);
    return (m == MODE_PERIM) ? 2 * (a + b) : a * b;
  endfunction

  task automatic send1(input int a, input logic m);
    int n = 0;
    while (!b8.rfd_in_1 && n < 200) begin tick(); n++; end
    b8.data_in_1 = a[7:0];
    b8.mode_in   = m;
    b8.dav_in_1_ = 1'b0;
    n = 0;
    do begin tick(); n++; end while (b8.rfd_in_1 && n < 200);
    b8.dav_in_1_ = 1'b1;
    chk("send1_ack", b8.rfd_in_1, 0);
  endtask

  task automatic send2(input int b);
    int n = 0;
    while (!b8.rfd_in_2 && n < 200) begin tick(); n++; end
    b8.data_in_2 = b[7:0];
    b8.dav_in_2_ = 1'b0;
    n = 0;
    do begin tick(); n++; end while (b8.rfd_in_2 && n < 200);
    b8.dav_in_2_ = 1'b1;
    chk("send2_ack", b8.rfd_in_2, 0);
  endtask

  task automatic recv(input int exp, input string tag);
    int n = 0;
    b8.rfd_out = 1'b1;
    while (b8.dav_out_ && n < 100) begin tick(); n++; end
    chk({tag, "_dav"}, b8.dav_out_, 0);
    chk(tag, b8.data_out, exp);
    b8.rfd_out = 1'b0;
    n = 0;
    while (!b8.dav_out_ && n < 100) begin tick(); n++; end
    chk({tag, "_rel"}, b8.dav_out_, 1);
  endtask

  task automatic run(input int a, input int b, input logic m, input string tag);
    fork
      send1(a, m);
      send2(b);
    join
    recv(model(a, b, m), tag);
  endtask

  task automatic run4(input int a, input int b, input logic m, input string tag);
    int n = 0;
    b4.data_in_1 = a[3:0];
    b4.data_in_2 = b[3:0];
    b4.mode_in   = m;
    b4.dav_in_1_ = 1'b0;
    b4.dav_in_2_ = 1'b0;
    do begin tick(); n++; end while ((b4.rfd_in_1 || b4.rfd_in_2) && n < 50);
    b4.dav_in_1_ = 1'b1;
    b4.dav_in_2_ = 1'b1;
    b4.rfd_out   = 1'b1;
    n = 0;
    while (b4.dav_out_ && n < 100) begin tick(); n++; end
    chk({tag, "_dav"}, b4.dav_out_, 0);
    chk(tag, b4.data_out, model(a, b, m));
    b4.rfd_out = 1'b0;
    n = 0;
    while (!b4.dav_out_ && n < 100) begin tick(); n++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic bad;
    int a, b, a2, b2, d1, d2;
    logic m, m2;

    b8.data_in_1 = '0; b8.data_in_2 = '0; b8.mode_in = 1'b0;
    b8.dav_in_1_ = 1'b1; b8.dav_in_2_ = 1'b1; b8.rfd_out = 1'b0;
    b4.data_in_1 = '0; b4.data_in_2 = '0; b4.mode_in = 1'b0;
    b4.dav_in_1_ = 1'b1; b4.dav_in_2_ = 1'b1; b4.rfd_out = 1'b0;
    repeat (3) tick();
    chk("rst_rfd1", b8.rfd_in_1, 1);
    chk("rst_rfd2", b8.rfd_in_2, 1);
    chk("rst_dav_out", b8.dav_out_, 1);
    chk("rst_data_out", b8.data_out, 0);
    reset = 1'b0;
    tick();

    // Area latency: simultaneous handshake, result exactly W+1 edges after LOAD
    b8.data_in_1 = 8'd13; b8.mode_in = MODE_AREA; b8.data_in_2 = 8'd11;
    b8.dav_in_1_ = 1'b0; b8.dav_in_2_ = 1'b0;
    tick();
    chk("ack_rfd1", b8.rfd_in_1, 0);
    chk("ack_rfd2", b8.rfd_in_2, 0);
    b8.dav_in_1_ = 1'b1; b8.dav_in_2_ = 1'b1;
    tick();
    chk("full_rfd1", b8.rfd_in_1, 0);
    tick();
    chk("load_rfd1", b8.rfd_in_1, 1);
    chk("load_rfd2", b8.rfd_in_2, 1);
    repeat (7) tick();
    chk("mul_busy_dav", b8.dav_out_, 1);
    tick();
    chk("area_lat9", b8.data_out, 143);
    repeat (3) tick();
    chk("no_dav_wo_rfd", b8.dav_out_, 1);
    chk("hold_data", b8.data_out, 143);
    recv(143, "area_13x11");

    // Perimeter latency: result two edges after LOAD
    b8.data_in_1 = 8'd13; b8.mode_in = MODE_PERIM; b8.data_in_2 = 8'd11;
    b8.dav_in_1_ = 1'b0; b8.dav_in_2_ = 1'b0;
    tick();
    b8.dav_in_1_ = 1'b1; b8.dav_in_2_ = 1'b1;
    repeat (2) tick();
    chk("perim_load", b8.rfd_in_1, 1);
    tick();
    chk("perim_lat2", b8.data_out, 48);
    recv(48, "perim_13_11");

    run(255, 255, MODE_AREA, "area_255x255");
    run(0, 200, MODE_AREA, "area_0x200");
    run(255, 255, MODE_PERIM, "perim_255_255");

    // Producer 2 arrives 20 cycles late
    send1(200, MODE_AREA);
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (b8.rfd_in_1 !== 1'b0 || b8.dav_out_ !== 1'b1) bad = 1'b1;
    end
    chk("late_ch2_hold", bad, 0);
    send2(77);
    recv(model(200, 77, MODE_AREA), "late_ch2");

    // Back-to-back: second pair accepted during MUL, FULL channel ignores dav_
    a = 91; b = 173; a2 = 44; b2 = 250; m2 = MODE_PERIM;
    fork
      send1(a, MODE_AREA);
      send2(b);
    join
    n = 0;
    while (!b8.rfd_in_1 && n < 50) begin tick(); n++; end
    chk("b2b_load1", b8.rfd_in_1, 1);
    fork
      send1(a2, m2);
      send2(b2);
    join
    tick();
    chk("b2b_held1", b8.rfd_in_1, 0);
    chk("b2b_held2", b8.rfd_in_2, 0);
    b8.data_in_1 = 8'hAA; b8.mode_in = MODE_AREA; b8.dav_in_1_ = 1'b0;
    repeat (3) tick();
    chk("full_ignores_dav", b8.rfd_in_1, 0);
    b8.dav_in_1_ = 1'b1;
    recv(model(a, b, MODE_AREA), "b2b_first");
    recv(model(a2, b2, m2), "b2b_second");

    // Reset on MUL step 4, with a pending operand in channel 1
    fork
      send1(9, MODE_AREA);
      send2(7);
    join
    n = 0;
    while (!b8.rfd_in_1 && n < 50) begin tick(); n++; end
    b8.data_in_1 = 8'd99; b8.mode_in = MODE_PERIM; b8.dav_in_1_ = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    b8.dav_in_1_ = 1'b1;
    b8.rfd_out = 1'b1;
    tick();
    chk("mrst_rfd1", b8.rfd_in_1, 1);
    chk("mrst_rfd2", b8.rfd_in_2, 1);
    chk("mrst_dav_out", b8.dav_out_, 1);
    chk("mrst_data_out", b8.data_out, 0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      tick();
      if (b8.dav_out_ !== 1'b1) bad = 1'b1;
    end
    chk("mrst_no_result", bad, 0);
    b8.rfd_out = 1'b0;
    tick();
    run(21, 4, MODE_AREA, "post_reset");

    // W=4 instance
    run4(15, 15, MODE_AREA, "w4_area_15x15");
    run4(15, 15, MODE_PERIM, "w4_perim_15_15");
    run4(0, 9, MODE_AREA, "w4_area_0x9");

    // Randomized transactions with independent producer skew
    for (int i = 0; i < 25; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      m  = $urandom_range(0, 1) == 1 ? MODE_PERIM : MODE_AREA;
      d1 = int'($urandom_range(0, 4));
      d2 = int'($urandom_range(0, 4));
      fork
        begin repeat (d1) tick(); send1(a, m); end
        begin repeat (d2) tick(); send2(b); end
      join
      repeat ($urandom_range(0, 3)) tick();
      recv(model(a, b, m), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_calc_param.md
RECT_CALC_PARAM -- requirements
Module: rect_calc_param

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be legal for W >= 2.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 data_in_1  input  W  operand A from producer 1.
REQ-005 dav_in_1_  input  1  producer 1 data valid, active low.
REQ-006 rfd_in_1  output  1  ready-for-data to producer 1, active high.
REQ-007 data_in_2  input  W  operand B from producer 2.
REQ-008 dav_in_2_  input  1  producer 2 data valid, active low.
REQ-009 rfd_in_2  output  1  ready-for-data to producer 2, active high.
REQ-010 mode_in  input  1  operation select, sampled with operand A: 0 = area A*B, 1 = perimeter 2*(A+B).
REQ-011 data_out  output  2W  result, registered.
REQ-012 dav_out_  output  1  result valid to consumer, active low, registered.
REQ-013 rfd_out  input  1  consumer ready-for-data, active high.

Function
REQ-014 Each input channel SHALL run its own FSM: EMPTY (rfd=1) -> on dav_=0 capture data (channel 1 also captures mode_in) -> ACK (rfd=0) -> on dav_=1 -> FULL (rfd=0) -> on core LOAD -> EMPTY.
REQ-015 Channels SHALL be independent: either producer may complete its handshake any number of cycles before the other.
REQ-016 Core FSM states: IDLE, MUL, PER, OUT_WAIT, OUT_DAV.
REQ-017 IDLE: when both channels FULL -> LOAD A, B, mode; clear P; COUNT=W; next state MUL if mode=0, PER if mode=1; both channels return to EMPTY in the same edge.
REQ-018 MUL: each cycle P <= (P + (B[0] ? A<<W : 0)) >> 1 computed on 2W+1 bits, B <= B>>1, COUNT <= COUNT-1; leave to OUT_WAIT on the step where COUNT==1 (exactly W steps).
REQ-019 PER: one cycle, P <= (A + B) << 1, zero-extended to 2W bits; next OUT_WAIT.
REQ-020 OUT_WAIT: data_out=P, dav_out_=1; when rfd_out=1 -> OUT_DAV.
REQ-021 OUT_DAV: dav_out_=0, data_out stable; when rfd_out=0 -> IDLE with dav_out_=1.
REQ-022 data_out SHALL hold its last value outside LOAD/MUL/PER updates; consumer may only sample while dav_out_=0.
REQ-023 Latency LOAD-to-OUT_WAIT: W+1 edges for area, 2 edges for perimeter.
REQ-024 Buffering: new operands SHALL be accepted (channel FSMs run) while the core is in MUL/PER/OUT_*; they are held FULL until the next IDLE LOAD.
REQ-025 A channel in FULL SHALL ignore its dav_ and keep rfd=0.
REQ-026 Results are exact: area < 2^(2W), perimeter <= 2^(W+2)-4; no overflow for W >= 2.
REQ-027 Operand value 0 SHALL yield 0 for area; no early termination; timing independent of data.

Reset
REQ-028 On a rising edge with reset=1: both channels EMPTY (rfd_in_1=rfd_in_2=1), core IDLE, dav_out_=1, data_out=0, COUNT=0, captured operands cleared.
REQ-029 Reset mid-handshake or mid-compute SHALL discard all pending operands and results; no dav_out_ pulse follows.
REQ-030 reset SHALL take priority over every other event in the same cycle.

Structure
REQ-031 Shared package rect_calc_pkg SHALL hold the core and channel state encodings and the mode constants MODE_AREA=0, MODE_PERIM=1.
REQ-032 One channel sub-module, rect_calc_chan (parametrised by W+1 data bits), SHALL be instantiated twice; the shift-add step is inline.
REQ-033 COUNT width SHALL be $clog2(W+1) bits.

Verification (W=8 unless noted)
REQ-034 A=13, B=11, mode=0, simultaneous dav -> data_out=143 after 9 edges from LOAD, dav_out_=0 only after rfd_out=1.
REQ-035 A=255, B=255, mode=0 -> 65025; A=0, B=200 -> 0; repeat with W=4: 15*15 -> 225.
REQ-036 A=13, B=11, mode=1 -> 48 two edges after LOAD; A=B=255, mode=1 -> 1020.
REQ-037 Producer 2 handshakes 20 cycles after producer 1 -> rfd_in_1 stays 0, no LOAD until channel 2 FULL, correct product.
REQ-038 Back-to-back: second operand pair offered during MUL -> accepted, held, LOAD occurs in first IDLE after OUT_DAV; results in order.
REQ-039 reset=1 during MUL step 4 -> next edge rfd_in_1=rfd_in_2=1, dav_out_=1, data_out=0, no result emitted.
